// File: rtl/mac_stream_unit_if.sv
// Operand/result handshake bundle for mac_stream_unit; the unit uses the slave side.
// The master side is the operand source plus the result consumer.
interface mac_stream_unit_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 4
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out;
    logic              overflow;
    logic              busy;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  start, in_valid, A, B, out_ready,
        output in_ready, out_valid, out, overflow, busy, count
    );

    modport master (
        output start, in_valid, A, B, out_ready,
        input  in_ready, out_valid, out, overflow, busy, count
    );
endinterface

// File: rtl/mac_stream_unit.sv
// LEN-term dot product: multiply register then accumulate register; result valid two cycles after the final accept.
// Operands are accepted only in RUN; the result is held in DONE until out_ready.
module mac_stream_unit #(
    parameter int DATA_W   = 4,
    parameter int LEN      = 10,
    parameter int ACC_W    = 12,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    mac_stream_unit_if.slave  bus
);
    localparam int CNT_W  = $clog2(LEN + 1);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] mul_res;
    logic [PROD_W-1:0] prod_r;
    logic              prod_v;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    sum_u;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  acc;
    logic              step_ovf;
    logic [CNT_W-1:0]  count_r;
    logic              ovf_r;

    assign accept = (state == RUN) && bus.in_valid;

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (accept && (count_r == CNT_W'(LEN - 1))) state_nxt = FLUSH;
            end
            FLUSH: begin
                bus.busy  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are widened to the product width first so one multiplier serves both signednesses.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext    = PROD_W'($signed(bus.A));
            b_ext    = PROD_W'($signed(bus.B));
            prod_ext = ACC_W'($signed(prod_r));
        end else begin
            a_ext    = PROD_W'(bus.A);
            b_ext    = PROD_W'(bus.B);
            prod_ext = ACC_W'(prod_r);
        end
        mul_res = a_ext * b_ext;
    end

    always_comb begin
        sum_u   = {1'b0, acc} + {1'b0, prod_ext};
        acc_sum = sum_u[ACC_W-1:0];
        if (SIGNED != 0)
            step_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
        else
            step_ovf = sum_u[ACC_W];
        acc_nxt = acc_sum;
        // A signed overflow goes in the direction of the (shared) operand sign.
        if (step_ovf && (SATURATE != 0)) begin
            if (SIGNED == 0)
                acc_nxt = '1;
            else if (acc[ACC_W-1])
                acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
            else
                acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            prod_r  <= '0;
            prod_v  <= 1'b0;
            acc     <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state  <= state_nxt;
            prod_v <= accept;
            if (accept) begin
                prod_r  <= mul_res;
                count_r <= count_r + CNT_W'(1);
            end
            if ((state == IDLE) && bus.start) begin
                acc     <= '0;
                count_r <= '0;
                ovf_r   <= 1'b0;
            end else if (prod_v) begin
                acc <= acc_nxt;
                if (step_ovf) ovf_r <= 1'b1;
            end
        end
    end

    assign bus.out      = acc;
    assign bus.overflow = ovf_r;
    assign bus.count    = count_r;
endmodule

// File: tb/tb_mac_stream_unit.sv
// Directed bench: five parameterisations of mac_stream_unit share one operand stream, each started individually.
module tb_mac_stream_unit;
    logic       clk;
    logic       rst;
    logic [4:0] start_v;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;

    int n_cmp = 0;
    int n_err = 0;

    mac_stream_unit_if #(.DATA_W(4), .ACC_W(12), .CNT_W(4)) if0();
    mac_stream_unit_if #(.DATA_W(4), .ACC_W(10), .CNT_W(4)) if1();
    mac_stream_unit_if #(.DATA_W(4), .ACC_W(10), .CNT_W(4)) if2();
    mac_stream_unit_if #(.DATA_W(4), .ACC_W(12), .CNT_W(4)) if3();
    mac_stream_unit_if #(.DATA_W(4), .ACC_W(12), .CNT_W(1)) if4();

    mac_stream_unit #(.DATA_W(4), .LEN(10), .ACC_W(12), .SIGNED(0), .SATURATE(1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    mac_stream_unit #(.DATA_W(4), .LEN(10), .ACC_W(10), .SIGNED(0), .SATURATE(1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    mac_stream_unit #(.DATA_W(4), .LEN(10), .ACC_W(10), .SIGNED(0), .SATURATE(0))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    mac_stream_unit #(.DATA_W(4), .LEN(10), .ACC_W(12), .SIGNED(1), .SATURATE(1))
        u3 (.clk(clk), .rst(rst), .bus(if3));
    mac_stream_unit #(.DATA_W(4), .LEN(1), .ACC_W(12), .SIGNED(0), .SATURATE(1))
        u4 (.clk(clk), .rst(rst), .bus(if4));

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if3.start = start_v[3];
    assign if4.start = start_v[4];
    assign {if0.in_valid, if1.in_valid, if2.in_valid, if3.in_valid, if4.in_valid} = {5{in_valid}};
    assign {if0.out_ready, if1.out_ready, if2.out_ready, if3.out_ready, if4.out_ready} = {5{out_ready}};
    assign {if0.A, if1.A, if2.A, if3.A, if4.A} = {5{a}};
    assign {if0.B, if1.B, if2.B, if3.B, if4.B} = {5{b}};

    logic [31:0] res [5];
    logic [31:0] cnt [5];
    logic        vld [5];
    logic        rdy [5];
    logic        bsy [5];
    logic        ovf [5];

    assign res[0] = 32'(if0.out);   assign cnt[0] = 32'(if0.count);
    assign res[1] = 32'(if1.out);   assign cnt[1] = 32'(if1.count);
    assign res[2] = 32'(if2.out);   assign cnt[2] = 32'(if2.count);
    assign res[3] = 32'(if3.out);   assign cnt[3] = 32'(if3.count);
    assign res[4] = 32'(if4.out);   assign cnt[4] = 32'(if4.count);
    assign vld = '{if0.out_valid, if1.out_valid, if2.out_valid, if3.out_valid, if4.out_valid};
    assign rdy = '{if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready, if4.in_ready};
    assign bsy = '{if0.busy, if1.busy, if2.busy, if3.busy, if4.busy};
    assign ovf = '{if0.overflow, if1.overflow, if2.overflow, if3.overflow, if4.overflow};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic start_run(input int s);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        chk("start_in_ready", 32'(rdy[s]), 1);
        chk("start_count_clr", cnt[s], 0);
        chk("start_ovf_clr", 32'(ovf[s]), 0);
    endtask

    // gap selects a valid-gap-gap cadence; poke pulses start while the run is in progress.
    task automatic feed(input int s, input int n, input bit gap, input bit poke);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 100) begin
            in_valid   = !gap || (cyc % 3 == 0);
            start_v[s] = poke && (cyc == 2);
            if (in_valid && rdy[s]) sent++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start_v  = '0;
        chk("feed_accepts", 32'(sent), 32'(n));
    endtask

    task automatic finish_run(input int s, input int n, input logic [31:0] exp_res, input logic exp_ovf);
        chk("flush_out_valid", 32'(vld[s]), 0);
        chk("flush_busy", 32'(bsy[s]), 1);
        chk("flush_in_ready", 32'(rdy[s]), 0);
        chk("flush_count", cnt[s], 32'(n));
        @(negedge clk);
        chk("done_out_valid", 32'(vld[s]), 1);
        chk("done_busy", 32'(bsy[s]), 0);
        chk("done_result", res[s], exp_res);
        chk("done_overflow", 32'(ovf[s]), 32'(exp_ovf));
        chk("done_count", cnt[s], 32'(n));
    endtask

    task automatic ack(input int s);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ack_out_valid", 32'(vld[s]), 0);
        chk("ack_in_ready", 32'(rdy[s]), 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; start_v = '0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        #12;
        chk("rst_out", res[0], 0);
        chk("rst_flags", {28'd0, vld[0], rdy[0], bsy[0], ovf[0]}, 0);
        chk("rst_count", cnt[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 10 x 15*15 back to back
        a = 4'd15; b = 4'd15;
        start_run(0);
        feed(0, 10, 1'b0, 1'b0);
        finish_run(0, 10, 32'd2250, 1'b0);
        ack(0);

        // gapped stream with a stray start mid-run, then a held result
        start_run(0);
        feed(0, 10, 1'b1, 1'b1);
        finish_run(0, 10, 32'd2250, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", res[0], 32'd2250);
            chk("hold_out_valid", 32'(vld[0]), 1);
            chk("hold_in_ready", 32'(rdy[0]), 0);
        end
        in_valid = 1'b0;
        ack(0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_count_held", cnt[0], 10);
        chk("idle_result_held", res[0], 32'd2250);
        chk("idle_busy", 32'(bsy[0]), 0);

        // narrow accumulator: saturate, then sticky flag cleared by the next start
        start_run(1);
        feed(1, 10, 1'b0, 1'b0);
        finish_run(1, 10, 32'd1023, 1'b1);
        ack(1);
        a = 4'd1; b = 4'd1;
        start_run(1);
        feed(1, 10, 1'b0, 1'b0);
        finish_run(1, 10, 32'd10, 1'b0);
        ack(1);

        // narrow accumulator, wrapping
        a = 4'd15; b = 4'd15;
        start_run(2);
        feed(2, 10, 1'b0, 1'b0);
        finish_run(2, 10, 32'd202, 1'b1);
        ack(2);

        // signed: -8*7 and -8*-8
        a = 4'b1000; b = 4'd7;
        start_run(3);
        feed(3, 10, 1'b0, 1'b0);
        finish_run(3, 10, 32'hDD0, 1'b0);
        ack(3);
        a = 4'b1000; b = 4'b1000;
        start_run(3);
        feed(3, 10, 1'b0, 1'b0);
        finish_run(3, 10, 32'd640, 1'b0);
        ack(3);

        // abort after 4 pairs: three products retired, fourth still in the multiply register
        a = 4'd15; b = 4'd15;
        start_run(0);
        feed(0, 4, 1'b0, 1'b0);
        chk("abort_count", cnt[0], 4);
        chk("abort_partial", res[0], 32'd675);
        rst = 1'b0;
        #1;
        chk("abort_out", res[0], 0);
        chk("abort_flags", {28'd0, vld[0], rdy[0], bsy[0], ovf[0]}, 0);
        chk("abort_count_clr", cnt[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        a = 4'd1; b = 4'd1;
        start_run(0);
        feed(0, 10, 1'b0, 1'b0);
        finish_run(0, 10, 32'd10, 1'b0);
        ack(0);

        // single-term run
        a = 4'd3; b = 4'd5;
        start_run(4);
        feed(4, 1, 1'b0, 1'b0);
        finish_run(4, 1, 32'd15, 1'b0);
        ack(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
